// File: rtl/activation_pipe.sv
// Two-stage multi-lane activation (bypass / ReLU / leaky / clamp) with valid/ready flow control.
// Optional zeroed-lane statistics counter enabled by defining ACTIVATION_STATS_EN.
module activation_pipe #(
  parameter int unsigned NUM_WIDTH  = 16,
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     cfg_mode,
  input  logic [NUM_WIDTH-1:0]           cfg_ceiling,
  input  logic                           up_valid,
  output logic                           up_ready,
  input  logic [NUM_LANES*NUM_WIDTH-1:0] up_data,
  output logic                           dn_valid,
  input  logic                           dn_ready,
  output logic [NUM_LANES*NUM_WIDTH-1:0] dn_data
`ifdef ACTIVATION_STATS_EN
  ,
  input  logic                           stat_clear,
  output logic [31:0]                    stat_zeroed
`endif
);

  localparam int unsigned BUS_W = NUM_LANES * NUM_WIDTH;
  localparam int unsigned ZC_W  = $clog2(NUM_LANES + 1);

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd1;
  localparam logic [1:0] MODE_LEAKY  = 2'd2;
  localparam logic [1:0] MODE_CLAMP  = 2'd3;

  logic                 s1_valid;
  logic [BUS_W-1:0]     s1_data;
  logic [1:0]           s1_mode;
  logic [NUM_WIDTH-2:0] s1_ceil;
  logic [BUS_W-1:0]     s1_result;
  logic                 s1_load;
  logic                 s2_load;

  // Ceiling MSB is architecturally ignored; only the low bits travel with the beat.
  logic unused_ceil_msb;
  assign unused_ceil_msb = cfg_ceiling[NUM_WIDTH-1];

  function automatic logic [NUM_WIDTH-1:0] act_lane(
    input logic [NUM_WIDTH-1:0] x,
    input logic [1:0]           mode,
    input logic [NUM_WIDTH-2:0] ceil
  );
    logic [NUM_WIDTH-1:0] c;
    logic                 neg;
    c   = {1'b0, ceil};
    neg = x[NUM_WIDTH-1];
    act_lane = x;
    case (mode)
      MODE_RELU:  if (neg) act_lane = '0;
      MODE_LEAKY: if (neg) act_lane = NUM_WIDTH'($signed(x) >>> LEAK_SHIFT);
      MODE_CLAMP: begin
        if (neg)        act_lane = '0;
        else if (x > c) act_lane = c;
      end
      MODE_BYPASS: act_lane = x;
      default:     act_lane = x;
    endcase
  endfunction

  assign s2_load  = !dn_valid || dn_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign up_ready = s1_load;

  always_comb begin
    s1_result = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      s1_result[i*NUM_WIDTH +: NUM_WIDTH] =
        act_lane(s1_data[i*NUM_WIDTH +: NUM_WIDTH], s1_mode, s1_ceil);
    end
  end

  // S1: capture beat together with its mode and ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
      s1_ceil  <= '0;
    end else if (s1_load) begin
      s1_valid <= up_valid;
      if (up_valid) begin
        s1_data <= up_data;
        s1_mode <= cfg_mode;
        s1_ceil <= cfg_ceiling[NUM_WIDTH-2:0];
      end
    end
  end

  // S2: activated result, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (s2_load) begin
      dn_valid <= s1_valid;
      if (s1_valid) dn_data <= s1_result;
    end
  end

`ifdef ACTIVATION_STATS_EN
  logic [ZC_W-1:0] s1_zero_cnt;
  logic [ZC_W-1:0] s2_zero_cnt;
  logic [32:0]     stat_sum;

  always_comb begin
    s1_zero_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (s1_data[i*NUM_WIDTH + NUM_WIDTH - 1] &&
          ((s1_mode == MODE_RELU) || (s1_mode == MODE_CLAMP)))
        s1_zero_cnt = s1_zero_cnt + ZC_W'(1);
    end
  end

  assign stat_sum = {1'b0, stat_zeroed} + 33'(s2_zero_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_zero_cnt <= '0;
    end else if (s2_load && s1_valid) begin
      s2_zero_cnt <= s1_zero_cnt;
    end
  end

  // Saturating count of lanes zeroed by negative input; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_zeroed <= '0;
    end else if (stat_clear) begin
      stat_zeroed <= '0;
    end else if (dn_valid && dn_ready) begin
      stat_zeroed <= stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_activation_pipe.sv
// Directed self-checking bench for activation_pipe (stats checks when ACTIVATION_STATS_EN defined).
module tb_activation_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned BW = W * L;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_ceiling;
  logic          up_valid;
  logic          up_ready;
  logic [BW-1:0] up_data;
  logic          dn_valid;
  logic          dn_ready;
  logic [BW-1:0] dn_data;
`ifdef ACTIVATION_STATS_EN
  logic          stat_clear;
  logic [31:0]   stat_zeroed;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  activation_pipe #(.NUM_WIDTH(W), .NUM_LANES(L), .LEAK_SHIFT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_mode    (cfg_mode),
    .cfg_ceiling (cfg_ceiling),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .up_data     (up_data),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready),
    .dn_data     (dn_data)
`ifdef ACTIVATION_STATS_EN
    ,
    .stat_clear  (stat_clear),
    .stat_zeroed (stat_zeroed)
`endif
  );

  function automatic logic [BW-1:0] pack(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one beat into an empty pipe with dn_ready high and reports what came out.
  task automatic single_beat(input logic [1:0] mode, input logic [W-1:0] ceil,
                             input logic [BW-1:0] data, output logic rdy,
                             output logic v_early, output logic v_out,
                             output logic [BW-1:0] d_out, output logic v_after);
    cfg_mode = mode; cfg_ceiling = ceil; up_data = data; up_valid = 1'b1; dn_ready = 1'b1;
    #1;
    rdy = up_ready;
    step();
    up_valid = 1'b0; cfg_mode = 2'd0;
    v_early = dn_valid;
    step();
    v_out = dn_valid; d_out = dn_data;
    step();
    v_after = dn_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; cfg_mode = 2'd0;
    cfg_ceiling = '0; up_data = '0;
`ifdef ACTIVATION_STATS_EN
    stat_clear = 1'b0;
`endif
    #23;
    checks++; if (dn_valid !== 1'b0) begin failures++; $display("FAIL reset_dn_valid got=%b exp=0", dn_valid); end
    checks++; if (dn_data !== '0) begin failures++; $display("FAIL reset_dn_data got=%h exp=0", dn_data); end
    checks++; if (up_ready !== 1'b1) begin failures++; $display("FAIL reset_up_ready got=%b exp=1", up_ready); end
`ifdef ACTIVATION_STATS_EN
    checks++; if (stat_zeroed !== 32'd0) begin failures++; $display("FAIL reset_stat got=%0d exp=0", stat_zeroed); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_mode(input string name, input logic [1:0] mode, input logic [W-1:0] ceil,
                          input logic [BW-1:0] data, input logic [BW-1:0] exp);
    logic r, ve, vo, va;
    logic [BW-1:0] d;
    single_beat(mode, ceil, data, r, ve, vo, d, va);
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL %s_up_ready got=%b exp=1", name, r); end
    checks++; if (ve !== 1'b0) begin failures++; $display("FAIL %s_early_valid got=%b exp=0", name, ve); end
    checks++; if (vo !== 1'b1) begin failures++; $display("FAIL %s_dn_valid got=%b exp=1", name, vo); end
    checks++; if (d !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, d, exp); end
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL %s_valid_one_cycle got=%b exp=0", name, va); end
  endtask

  task automatic test_relu();
    run_mode("relu", 2'd1, 16'h0000, pack(16'hFFFB, 16'h0000, 16'h0007, 16'h8000),
             pack(16'h0000, 16'h0000, 16'h0007, 16'h0000));
  endtask

  task automatic test_leaky();
    run_mode("leaky", 2'd2, 16'h0000, pack(16'hFFF8, 16'hFFFF, 16'hFF9C, 16'h0028),
             pack(16'hFFFF, 16'hFFFF, 16'hFFF3, 16'h0028));
  endtask

  task automatic test_clamp();
    run_mode("clamp", 2'd3, 16'h8064, pack(16'd150, 16'd100, 16'hFFFD, 16'd99),
             pack(16'd100, 16'd100, 16'd0, 16'd99));
  endtask

  task automatic test_bypass();
    run_mode("bypass", 2'd0, 16'h0000, pack(16'h8000, 16'hFFFF, 16'h1234, 16'h7FFF),
             pack(16'h8000, 16'hFFFF, 16'h1234, 16'h7FFF));
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] beats [4];
    logic [BW-1:0] held;
    logic          was_stalled;
    logic          saw_ready_low;
    int            in_idx, out_idx;
    for (int i = 0; i < 4; i++)
      beats[i] = pack(16'(16'h100 + i), 16'(16'h200 + i), 16'(16'h300 + i), 16'(16'h400 + i));
    in_idx = 0; out_idx = 0; was_stalled = 1'b0; saw_ready_low = 1'b0; held = '0;
    cfg_mode = 2'd0;
    for (int c = 0; c < 20; c++) begin
      dn_ready = !(c >= 2 && c <= 4);
      up_valid = (in_idx < 4);
      up_data  = (in_idx < 4) ? beats[in_idx] : '0;
      #1;
      if (was_stalled) begin
        checks++; if (dn_valid !== 1'b1 || dn_data !== held) begin
          failures++; $display("FAIL b2b_stall_stable got=%b/%h exp=1/%h", dn_valid, dn_data, held);
        end
      end
      if (c >= 2 && c <= 4) begin
        checks++; if (up_ready !== 1'b0) begin
          failures++; $display("FAIL b2b_up_ready_stall cyc=%0d got=%b exp=0", c, up_ready);
        end else saw_ready_low = 1'b1;
      end
      if (dn_valid && dn_ready) begin
        checks++;
        if (out_idx >= 4) begin
          failures++; $display("FAIL b2b_extra_beat got=%h exp=none", dn_data);
        end else if (dn_data !== beats[out_idx]) begin
          failures++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", out_idx, dn_data, beats[out_idx]);
        end
        out_idx++;
      end
      was_stalled = dn_valid && !dn_ready;
      held = dn_data;
      if (up_valid && up_ready) in_idx++;
      step();
    end
    up_valid = 1'b0; dn_ready = 1'b1;
    checks++; if (out_idx != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", out_idx); end
    checks++; if (saw_ready_low !== 1'b1) begin failures++; $display("FAIL b2b_backpressure got=%b exp=1", saw_ready_low); end
  endtask

  task automatic test_mode_switch();
    logic [BW-1:0] exp [4];
    int in_idx, out_idx;
    exp[0] = '0; exp[1] = {L{16'hFFFE}}; exp[2] = '0; exp[3] = {L{16'hFFFE}};
    in_idx = 0; out_idx = 0; dn_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      up_valid = (in_idx < 4);
      cfg_mode = in_idx[0] ? 2'd0 : 2'd1;
      up_data  = {L{16'hFFFE}};
      #1;
      if (dn_valid && dn_ready) begin
        checks++;
        if (out_idx >= 4) begin
          failures++; $display("FAIL modesw_extra got=%h exp=none", dn_data);
        end else if (dn_data !== exp[out_idx]) begin
          failures++; $display("FAIL modesw_beat%0d got=%h exp=%h", out_idx, dn_data, exp[out_idx]);
        end
        out_idx++;
      end
      if (up_valid && up_ready) in_idx++;
      step();
    end
    up_valid = 1'b0; cfg_mode = 2'd0;
    checks++; if (out_idx != 4) begin failures++; $display("FAIL modesw_count got=%0d exp=4", out_idx); end
  endtask

  task automatic test_reset_full();
    dn_ready = 1'b0; cfg_mode = 2'd0; up_valid = 1'b1;
    up_data = pack(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    step();
    up_data = pack(16'h0055, 16'h0066, 16'h0077, 16'h0088);
    step();
    up_valid = 1'b0;
    checks++; if (dn_valid !== 1'b1 || up_ready !== 1'b0) begin
      failures++; $display("FAIL rstfull_prefill got=%b/%b exp=1/0", dn_valid, up_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dn_valid !== 1'b0) begin failures++; $display("FAIL rstfull_dn_valid got=%b exp=0", dn_valid); end
    checks++; if (dn_data !== '0) begin failures++; $display("FAIL rstfull_dn_data got=%h exp=0", dn_data); end
    #3 rst_n = 1'b1;
    dn_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (dn_valid !== 1'b0) begin
        failures++; $display("FAIL rstfull_no_output cyc=%0d got=%b exp=0", c, dn_valid);
      end
    end
  endtask

`ifdef ACTIVATION_STATS_EN
  task automatic stat_beat(input logic [1:0] mode, input logic [BW-1:0] data, input logic clr);
    cfg_mode = mode; cfg_ceiling = 16'd50; up_data = data; up_valid = 1'b1; dn_ready = 1'b1;
    step();
    up_valid = 1'b0;
    step();
    stat_clear = clr;
    step();
    stat_clear = 1'b0;
  endtask

  task automatic test_stats();
    logic [BW-1:0] neg2;
    neg2 = pack(16'hFFFB, 16'h0000, 16'h0007, 16'h8000);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    stat_beat(2'd1, neg2, 1'b0);
    checks++; if (stat_zeroed !== 32'd2) begin failures++; $display("FAIL stat_relu got=%0d exp=2", stat_zeroed); end
    stat_beat(2'd2, neg2, 1'b0);
    checks++; if (stat_zeroed !== 32'd2) begin failures++; $display("FAIL stat_leaky got=%0d exp=2", stat_zeroed); end
    stat_beat(2'd3, pack(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'd99), 1'b0);
    checks++; if (stat_zeroed !== 32'd5) begin failures++; $display("FAIL stat_clamp got=%0d exp=5", stat_zeroed); end
    stat_beat(2'd1, neg2, 1'b1);
    checks++; if (stat_zeroed !== 32'd0) begin failures++; $display("FAIL stat_clear got=%0d exp=0", stat_zeroed); end
  endtask
`endif

  initial begin
    test_reset();
    test_relu();
    test_leaky();
    test_clamp();
    test_bypass();
    test_back_to_back();
    test_mode_switch();
`ifdef ACTIVATION_STATS_EN
    test_stats();
`endif
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
